// File: rtl/fp_pkg.sv
// ============================================================================
// Module : fp_pkg
// Brief  : Shared constants, FSM state enum and packed IEEE-754 word struct.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fp_pkg;

    localparam int FP_W       = 32;
    localparam int FP_EXP_W   = 8;
    localparam int FP_FRAC_W  = 23;

    localparam logic [FP_EXP_W-1:0] EXP_MAX    = 8'hFF;
    localparam logic [FP_EXP_W-1:0] EXP_OVF_IN = 8'hFE;

    localparam int HIDDEN_BIT = 23;
    localparam int CARRY_BIT  = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_FRAC_W-1:0] frac;
    } fp_word_t;

endpackage

`default_nettype wire

// File: rtl/fp_add_normalizer.sv
// ============================================================================
// Module : fp_add_normalizer
// Brief  : Post-add normalizer; left shifts one bit per cycle, packs IEEE word.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fp_add_normalizer
    import fp_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int FRAC_W = FP_FRAC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [FRAC_W+1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FP_W-1:0]   out_result,
    output logic              out_ovf,
    output logic              out_unf,
    output logic              out_zero
);

    localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [EXP_W-1:0] EXP_ZERO = '0;

    state_t              state_q, state_d;
    logic                sign_q,  sign_d;
    logic [EXP_W-1:0]    exp_q,   exp_d;
    logic [FRAC_W+1:0]   mant_q,  mant_d;
    fp_word_t            result_q, result_d;
    logic                ovf_q,   ovf_d;
    logic                unf_q,   unf_d;
    logic                zero_q,  zero_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            zero_q   <= zero_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d   = in_sign;
                    exp_d    = in_exp;
                    mant_d   = in_mant;
                    result_d = '0;
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    zero_d   = 1'b0;
                    // Classification order matters: a carry at exponent 254 overflows
                    // before the carry shift is applied.
                    if (in_mant == '0) begin
                        zero_d  = 1'b1;
                        state_d = DONE;
                    end else if (in_exp == EXP_MAX ||
                                 (in_mant[CARRY_BIT] && in_exp == EXP_OVF_IN)) begin
                        result_d.sign = in_sign;
                        result_d.exp  = EXP_MAX;
                        ovf_d         = 1'b1;
                        state_d       = DONE;
                    end else if (in_mant[CARRY_BIT]) begin
                        mant_d  = in_mant >> 1;
                        exp_d   = in_exp + EXP_ONE;
                        state_d = SHIFT;
                    end else if (in_exp == EXP_ZERO) begin
                        unf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end

            SHIFT: begin
                if (mant_q[HIDDEN_BIT]) begin
                    result_d.sign = sign_q;
                    result_d.exp  = exp_q;
                    result_d.frac = mant_q[FRAC_W-1:0];
                    state_d       = DONE;
                end else if (exp_q == EXP_ONE) begin
                    result_d = '0;
                    unf_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    mant_d = mant_q << 1;
                    exp_d  = exp_q - EXP_ONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_result = result_q;
    assign out_ovf    = ovf_q;
    assign out_unf    = unf_q;
    assign out_zero   = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_add_normalizer.sv
// ============================================================================
// Module : tb_fp_add_normalizer
// Brief  : Scoreboard bench for the post-add normalizer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fp_add_normalizer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_ovf;
    logic        out_unf;
    logic        out_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        zero;
        int          lat;
    } exp_t;

    exp_t sb[$];

    fp_add_normalizer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ovf    (out_ovf),
        .out_unf    (out_unf),
        .out_zero   (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference: leading-zero count drives the shift amount directly.
    function automatic exp_t model(input logic s, input logic [7:0] e, input logic [24:0] m);
        exp_t r;
        int   l;
        int   msb;
        logic [24:0] mm;
        r.res = '0; r.ovf = 1'b0; r.unf = 1'b0; r.zero = 1'b0; r.lat = 0;
        if (m == 25'h0) begin
            r.zero = 1'b1; r.lat = 1;
        end else if (e == 8'hFF || (m[24] && e == 8'hFE)) begin
            r.res = {s, 8'hFF, 23'h0}; r.ovf = 1'b1; r.lat = 1;
        end else if (m[24]) begin
            r.res = {s, e + 8'd1, m[23:1]}; r.lat = 2;
        end else if (e == 8'h00) begin
            r.unf = 1'b1; r.lat = 1;
        end else begin
            msb = 0;
            for (int i = 0; i < 24; i++) if (m[i]) msb = i;
            l  = 23 - msb;
            mm = m << l;
            if (int'(e) > l) begin
                r.res = {s, 8'(int'(e) - l), mm[22:0]};
                r.lat = l + 2;
            end else begin
                r.unf = 1'b1;
                r.lat = int'(e) + 1;
            end
        end
        return r;
    endfunction

    task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m,
                        input exp_t ex, input int hold, input string tag);
        exp_t got;
        int   n;
        logic busy_bad;
        @(negedge clk);
        chk({tag, "_in_ready_idle"}, {31'h0, in_ready}, 32'h1);
        in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
        sb.push_back(ex);
        @(negedge clk);
        in_valid = 1'b0;
        in_sign  = 1'($urandom); in_exp = 8'($urandom); in_mant = 25'($urandom);
        n = 1;
        busy_bad = 1'b0;
        while (!out_valid && n < 40) begin
            if (in_ready) busy_bad = 1'b1;
            in_exp = 8'($urandom); in_mant = 25'($urandom);
            @(negedge clk);
            n++;
        end
        got = sb.pop_front();
        if (!out_valid) begin
            chk({tag, "_timeout"}, {31'h0, out_valid}, 32'h1);
            return;
        end
        chk({tag, "_in_ready_busy"}, {31'h0, busy_bad}, 32'h0);
        chk({tag, "_latency"}, 32'(n), 32'(got.lat));
        chk({tag, "_result"}, out_result, got.res);
        chk({tag, "_flags"}, {29'h0, out_ovf, out_unf, out_zero},
            {29'h0, got.ovf, got.unf, got.zero});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, {31'h0, out_valid}, 32'h1);
            chk({tag, "_hold_result"}, out_result, got.res);
            chk({tag, "_hold_flags"}, {29'h0, out_ovf, out_unf, out_zero},
                {29'h0, got.ovf, got.unf, got.zero});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_retire"}, {30'h0, out_valid, in_ready}, 32'h1);
    endtask

    function automatic exp_t mk(input logic [31:0] res, input logic o, input logic u,
                                input logic z, input int lat);
        exp_t r;
        r.res = res; r.ovf = o; r.unf = u; r.zero = z; r.lat = lat;
        return r;
    endfunction

    initial begin
        logic        rs;
        logic [7:0]  re;
        logic [24:0] rm;
        logic [24:0] mask;
        int          n;
        logic        stale;

        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", {31'h0, out_valid}, 32'h0);
        chk("reset_result", out_result, 32'h0);
        chk("reset_flags", {29'h0, out_ovf, out_unf, out_zero}, 32'h0);
        chk("reset_in_ready", {31'h0, in_ready}, 32'h1);

        send(1'b0, 8'h7F, 25'h0800000, mk(32'h3F80_0000, 0, 0, 0, 2), 0, "norm");
        send(1'b0, 8'h7F, 25'h1800000, mk(32'h4040_0000, 0, 0, 0, 2), 1, "carry");
        send(1'b0, 8'h80, 25'h0000001, mk(32'h3480_0000, 0, 0, 0, 25), 0, "maxshift");
        send(1'b1, 8'h55, 25'h0000000, mk(32'h0000_0000, 0, 0, 1, 1), 0, "zero");
        send(1'b1, 8'hFE, 25'h1000000, mk(32'hFF80_0000, 1, 0, 0, 1), 2, "ovf_carry");
        send(1'b0, 8'hFF, 25'h0812345, mk(32'h7F80_0000, 1, 0, 0, 1), 0, "ovf_max");
        send(1'b0, 8'h02, 25'h0000100, mk(32'h0000_0000, 0, 1, 0, 3), 3, "unf_bp");
        send(1'b1, 8'h00, 25'h0400000, mk(32'h0000_0000, 0, 1, 0, 1), 0, "unf_exp0");
        send(1'b1, 8'h00, 25'h1000002, mk(32'h8080_0001, 0, 0, 0, 2), 0, "carry_exp0");

        for (int t = 0; t < 24; t++) begin
            rs   = 1'($urandom);
            re   = (t % 3 == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom);
            mask = (25'h1 << $urandom_range(0, 25)) - 25'h1;
            rm   = 25'($urandom) & mask;
            send(rs, re, rm, model(rs, re, rm), int'($urandom_range(0, 2)), "rand");
        end

        // Abort a long normalization partway through.
        @(negedge clk);
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'h80; in_mant = 25'h0000001;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_mid_result", out_result, 32'h0);
        chk("rst_mid_flags", {29'h0, out_ovf, out_unf, out_zero}, 32'h0);
        chk("rst_mid_in_ready", {31'h0, in_ready}, 32'h1);
        stale = 1'b0;
        for (n = 0; n < 30; n++) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        chk("rst_mid_no_stale", {31'h0, stale}, 32'h0);

        send(1'b1, 8'h81, 25'h0600000, model(1'b1, 8'h81, 25'h0600000), 0, "post_rst");
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
